// File: rtl/jump_button_conditioner.sv
// Jump button conditioner: 2-flop synchroniser, four-state debounce FSM, rising-edge pulse,
// sticky jump request with acknowledge, and a saturating press counter. All outputs registered.
module jump_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20,
  parameter int PRESS_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   button_raw,
  input  logic                   jump_ack,
  output logic                   btn_level,
  output logic                   btn_rise,
  output logic                   jump_req,
  output logic [PRESS_CNT_W-1:0] press_count
);

  // Handshake: jump_req rises on a debounced press and holds until a cycle with jump_ack=1
  // that is not itself a press edge; a press on the same edge as an ack always wins.

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PRESS_CNT_W-1:0] PRESS_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sync_meta;
  logic             sync_q;
  logic             rise_nxt;
  logic             level_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= button_raw;
      sync_q    <= sync_meta;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (sync_q) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_q) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!sync_q) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        // Returning to PRESSED from here is a rejected release bounce, not a new press.
        if (sync_q) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_rise    <= 1'b0;
      jump_req    <= 1'b0;
      press_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      btn_rise  <= rise_nxt;
      if (rise_nxt) begin
        jump_req <= 1'b1;
      end else if (jump_ack) begin
        jump_req <= 1'b0;
      end
      if (rise_nxt && (press_count != PRESS_MAX)) begin
        press_count <= press_count + 1'b1;
      end
    end
  end

endmodule
